// File: rtl/mem_wb_pkg.sv
// Shared types, default widths and payload sizing for the MEM/WB pipeline stage.
// Used by pipe_skid_buf and mem_wb_pipe.
package mem_wb_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } mem_wb_state_t;

    localparam int MEM_WB_DATA_W_DEF     = 32;
    localparam int MEM_WB_REG_ADDR_W_DEF = 5;

    // aluout + readdata + writereg + regwrite + memtoreg
    function automatic int PAYLOAD_W(input int data_w, input int reg_addr_w);
        return 2 * data_w + reg_addr_w + 2;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer with valid/ready handshake, synchronous flush and
// asynchronous active-low reset; flush clears the low FLUSH_CLR_W payload bits.
module pipe_skid_buf
    import mem_wb_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int FLUSH_CLR_W = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam logic [WIDTH-1:0] KEEP_MASK =
        ~((WIDTH'(1) << FLUSH_CLR_W) - WIDTH'(1));

    mem_wb_state_t    state_q;
    mem_wb_state_t    state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    assign in_ready  = (state_q != SKID);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;

    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_valid) begin
                    state_d      = FULL;
                    load_main_in = 1'b1;
                end
            end
            FULL: begin
                if (in_valid && out_ready) begin
                    load_main_in = 1'b1;
                end else if (in_valid) begin
                    state_d   = SKID;
                    load_skid = 1'b1;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            SKID: begin
                if (out_ready) begin
                    state_d        = FULL;
                    load_main_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins over every handshake and discards any same-cycle input.
        if (flush) begin
            state_d        = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                main_q <= main_q & KEEP_MASK;
                skid_q <= skid_q & KEEP_MASK;
            end else begin
                if (load_main_in) begin
                    main_q <= in_data;
                end else if (load_main_skid) begin
                    main_q <= skid_q;
                end
                if (load_skid) begin
                    skid_q <= in_data;
                end
            end
        end
    end

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: skid-buffered handshake, $zero write mask and result mux.
// Define MEM_WB_FWD_EN to add the fwd_en/fwd_reg/fwd_data hazard-unit outputs.
module mem_wb_pipe
    import mem_wb_pkg::*;
#(
    parameter int DATA_W     = MEM_WB_DATA_W_DEF,
    parameter int REG_ADDR_W = MEM_WB_REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     aluout_in,
    input  logic [DATA_W-1:0]     readdata_in,
    input  logic [REG_ADDR_W-1:0] writereg_in,
    input  logic                  regwrite_in,
    input  logic                  memtoreg_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     aluout_out,
    output logic [DATA_W-1:0]     readdata_out,
    output logic [REG_ADDR_W-1:0] writereg_out,
    output logic                  regwrite_out,
    output logic                  memtoreg_out,
`ifdef MEM_WB_FWD_EN
    output logic                  fwd_en,
    output logic [REG_ADDR_W-1:0] fwd_reg,
    output logic [DATA_W-1:0]     fwd_data,
`endif
    output logic [DATA_W-1:0]     result_out
);

    localparam int PW = PAYLOAD_W(DATA_W, REG_ADDR_W);

    logic [PW-1:0] payload_in;
    logic [PW-1:0] payload_out;
    logic          regwrite_masked;
    logic          regwrite_held;

    // Writes to register 0 are dropped here so WB and forwarding never see them.
    assign regwrite_masked = regwrite_in & (writereg_in != '0);
    assign payload_in = {aluout_in, readdata_in, writereg_in, regwrite_masked, memtoreg_in};

    pipe_skid_buf #(
        .WIDTH       (PW),
        .FLUSH_CLR_W (2)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (payload_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (payload_out)
    );

    assign {aluout_out, readdata_out, writereg_out, regwrite_held, memtoreg_out} = payload_out;
    assign regwrite_out = regwrite_held & out_valid;
    assign result_out   = memtoreg_out ? readdata_out : aluout_out;

`ifdef MEM_WB_FWD_EN
    assign fwd_en   = regwrite_out;
    assign fwd_reg  = writereg_out;
    assign fwd_data = result_out;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed self-checking bench for mem_wb_pipe; define MEM_WB_FWD_EN to also
// check the forwarding outputs.
module tb_mem_wb_pipe;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] aluout_in;
    logic [31:0] readdata_in;
    logic [4:0]  writereg_in;
    logic        regwrite_in;
    logic        memtoreg_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] aluout_out;
    logic [31:0] readdata_out;
    logic [4:0]  writereg_out;
    logic        regwrite_out;
    logic        memtoreg_out;
    logic [31:0] result_out;
`ifdef MEM_WB_FWD_EN
    logic        fwd_en;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
`endif

    int errors = 0;
    int checks = 0;

    mem_wb_pipe #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .aluout_in    (aluout_in),
        .readdata_in  (readdata_in),
        .writereg_in  (writereg_in),
        .regwrite_in  (regwrite_in),
        .memtoreg_in  (memtoreg_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .aluout_out   (aluout_out),
        .readdata_out (readdata_out),
        .writereg_out (writereg_out),
        .regwrite_out (regwrite_out),
        .memtoreg_out (memtoreg_out),
`ifdef MEM_WB_FWD_EN
        .fwd_en       (fwd_en),
        .fwd_reg      (fwd_reg),
        .fwd_data     (fwd_data),
`endif
        .result_out   (result_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1ns after the next rising edge; inputs change and outputs are sampled there.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rd,
                         input logic [4:0] wr, input logic rw, input logic mtr);
        in_valid    = v;
        aluout_in   = alu;
        readdata_in = rd;
        writereg_in = wr;
        regwrite_in = rw;
        memtoreg_in = mtr;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if ({aluout_out, readdata_out, writereg_out, regwrite_out, memtoreg_out, result_out} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_fields: got alu=%h rd=%h wr=%0d rw=%b mtr=%b res=%h expected all 0",
                     aluout_out, readdata_out, writereg_out, regwrite_out, memtoreg_out, result_out);
        end
        reset = 1'b1;
    endtask

    task automatic test_single();
        drive(1'b1, 32'hAAAAAAAA, 32'h55555555, 5'd10, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL single_valid: got %b expected 1", out_valid);
        end
        checks++;
        if (result_out !== 32'hAAAAAAAA || readdata_out !== 32'h55555555) begin
            errors++; $display("[TB] FAIL single_data: got res=%h rd=%h expected res=aaaaaaaa rd=55555555",
                               result_out, readdata_out);
        end
        checks++;
        if (writereg_out !== 5'd10 || regwrite_out !== 1'b1) begin
            errors++; $display("[TB] FAIL single_ctrl: got wr=%0d rw=%b expected wr=10 rw=1",
                               writereg_out, regwrite_out);
        end
`ifdef MEM_WB_FWD_EN
        checks++;
        if (fwd_en !== 1'b1 || fwd_reg !== 5'd10 || fwd_data !== 32'hAAAAAAAA) begin
            errors++; $display("[TB] FAIL single_fwd: got en=%b reg=%0d data=%h expected 1/10/aaaaaaaa",
                               fwd_en, fwd_reg, fwd_data);
        end
`endif
        step();
        checks++;
        if (out_valid !== 1'b0 || regwrite_out !== 1'b0) begin
            errors++; $display("[TB] FAIL single_drain: got valid=%b rw=%b expected 0/0", out_valid, regwrite_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_res;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 32'h200 + 32'(i), 5'(i + 1), 1'b1, i[0]);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("[TB] FAIL b2b_in_ready[%0d]: got %b expected 1", i, in_ready);
            end
            step();
            exp_res = i[0] ? 32'h200 + 32'(i) : 32'h100 + 32'(i);
            checks++;
            if (out_valid !== 1'b1 || writereg_out !== 5'(i + 1) || result_out !== exp_res) begin
                errors++; $display("[TB] FAIL b2b_entry[%0d]: got valid=%b wr=%0d res=%h expected 1/%0d/%h",
                                   i, out_valid, writereg_out, result_out, i + 1, exp_res);
            end
        end
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_drain: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        drive(1'b1, 32'h12345678, 32'h87654321, 5'd20, 1'b1, 1'b1);
        step();
        checks++;
        if (result_out !== 32'h87654321 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL skid_full: got res=%h ready=%b valid=%b expected 87654321/1/1",
                               result_out, in_ready, out_valid);
        end
        drive(1'b1, 32'h11111111, 32'h22222222, 5'd21, 1'b1, 1'b0);
        step();
        checks++;
        if (in_ready !== 1'b0 || writereg_out !== 5'd20 || result_out !== 32'h87654321) begin
            errors++; $display("[TB] FAIL skid_enter: got ready=%b wr=%0d res=%h expected 0/20/87654321",
                               in_ready, writereg_out, result_out);
        end
        drive(1'b1, 32'h33333333, 32'h44444444, 5'd22, 1'b1, 1'b0);
        step();
        checks++;
        if (in_ready !== 1'b0 || writereg_out !== 5'd20 || result_out !== 32'h87654321) begin
            errors++; $display("[TB] FAIL skid_stable: got ready=%b wr=%0d res=%h expected 0/20/87654321",
                               in_ready, writereg_out, result_out);
        end
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || writereg_out !== 5'd21 || result_out !== 32'h11111111 || in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL skid_release: got valid=%b wr=%0d res=%h ready=%b expected 1/21/11111111/1",
                               out_valid, writereg_out, result_out, in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL skid_no_dup: got valid=%b wr=%0d expected valid 0", out_valid, writereg_out);
        end
    endtask

    task automatic test_zero_mask();
        drive(1'b1, 32'hDEADBEEF, 32'h0, 5'd0, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || regwrite_out !== 1'b0 || result_out !== 32'hDEADBEEF) begin
            errors++; $display("[TB] FAIL zero_mask: got valid=%b rw=%b res=%h expected 1/0/deadbeef",
                               out_valid, regwrite_out, result_out);
        end
        step();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'd5, 1'b1, 1'b1);
        step();
        drive(1'b1, 32'hB0B0B0B0, 32'h0B0B0B0B, 5'd6, 1'b1, 1'b0);
        step();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_pre_skid: got ready=%b expected 0", in_ready);
        end
        flush = 1'b1;
        drive(1'b1, 32'hC0C0C0C0, 32'h0C0C0C0C, 5'd7, 1'b1, 1'b0);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || regwrite_out !== 1'b0 || memtoreg_out !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL flush_state: got valid=%b rw=%b mtr=%b ready=%b expected 0/0/0/1",
                               out_valid, regwrite_out, memtoreg_out, in_ready);
        end
        checks++;
        if (aluout_out !== 32'hA5A5A5A5) begin
            errors++; $display("[TB] FAIL flush_data_hold: got alu=%h expected a5a5a5a5", aluout_out);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_discard: got valid=%b wr=%0d expected valid 0", out_valid, writereg_out);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 32'h0F0F0F0F, 32'hF0F0F0F0, 5'd9, 1'b1, 1'b0);
        step();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || writereg_out !== 5'd9) begin
            errors++; $display("[TB] FAIL areset_pre: got valid=%b wr=%0d expected 1/9", out_valid, writereg_out);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || regwrite_out !== 1'b0 ||
            aluout_out !== 32'h0 || writereg_out !== 5'd0 || result_out !== 32'h0) begin
            errors++; $display("[TB] FAIL areset_now: got valid=%b ready=%b rw=%b alu=%h wr=%0d res=%h expected 0/1/0/0/0/0",
                               out_valid, in_ready, regwrite_out, aluout_out, writereg_out, result_out);
        end
`ifdef MEM_WB_FWD_EN
        checks++;
        if (fwd_en !== 1'b0 || fwd_reg !== 5'd0 || fwd_data !== 32'h0) begin
            errors++; $display("[TB] FAIL areset_fwd: got en=%b reg=%0d data=%h expected 0/0/0", fwd_en, fwd_reg, fwd_data);
        end
`endif
        step();
        reset = 1'b1;
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL areset_lost: got valid=%b expected 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_skid();
        test_zero_mask();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
